// File: rtl/shk_pkg.sv
// Shared types and default widths for the shk handshake slave.
package shk_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} shk_state_e;

  localparam int          SHK_DATA_W   = 32;
  localparam int          SHK_ADDR_W   = 32;
  localparam int          SHK_MEM_AW   = 8;
  localparam int          SHK_CNT_W    = 16;
  localparam logic [31:0] SHK_ERR_WORD = 32'hDEAD_BEEF;
endpackage

// File: rtl/shk_sp_ram.sv
// Single-port synchronous word RAM, registered read, contents not reset.
module shk_sp_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_o       <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/shk_mem_slave.sv
// Slave responder for the shk channel: writes ack in one cycle, reads block
// ready for two cycles while the single-port RAM is accessed.
module shk_mem_slave
  import shk_pkg::*;
#(
  parameter int                DATA_W   = SHK_DATA_W,
  parameter int                ADDR_W   = SHK_ADDR_W,
  parameter int                MEM_AW   = SHK_MEM_AW,
  parameter int                CNT_W    = SHK_CNT_W,
  parameter logic [DATA_W-1:0] ERR_WORD = SHK_ERR_WORD
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_resetn,
  input  logic              i_shk_valid,
  input  logic              i_shk_msync,
  input  logic [DATA_W-1:0] i_shk_mdata,
  input  logic [ADDR_W-1:0] i_shk_maddr,
  output logic              o_shk_ready,
  output logic              o_shk_ssync,
  output logic [DATA_W-1:0] o_shk_sdata,
  output logic [ADDR_W-1:0] o_shk_saddr,
  output logic [CNT_W-1:0]  o_wr_cnt,
  output logic [CNT_W-1:0]  o_rd_cnt,
  output logic [CNT_W-1:0]  o_err_cnt
);
  shk_state_e        state_q, state_d;
  logic              ready_q, ready_d, ssync_q, ssync_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d, raddr_q, raddr_d;
  logic              rinr_q, rinr_d;
  logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q, err_cnt_q;
  logic              wr_inc, rd_inc, err_inc;
  logic              acc, in_rng;
  logic              ram_en, ram_we;
  logic [MEM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rdata;

  assign acc    = i_shk_valid & ready_q & (state_q == IDLE);
  assign in_rng = (i_shk_maddr[ADDR_W-1:MEM_AW] == '0);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    ssync_d = 1'b0;
    sdata_d = sdata_q;
    saddr_d = saddr_q;
    raddr_d = raddr_q;
    rinr_d  = rinr_q;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    err_inc = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_idx = i_shk_maddr[MEM_AW-1:0];
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (acc && !i_shk_msync) begin
          ssync_d = 1'b1;
          saddr_d = i_shk_maddr;
          sdata_d = i_shk_mdata;
          ram_en  = in_rng;
          ram_we  = in_rng;
          wr_inc  = in_rng;
          err_inc = !in_rng;
        end else if (acc) begin
          raddr_d = i_shk_maddr;
          rinr_d  = in_rng;
          ready_d = 1'b0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        ready_d = 1'b0;
        ram_en  = rinr_q;
        ram_idx = raddr_q[MEM_AW-1:0];
        state_d = RD_RESP;
      end
      RD_RESP: begin
        ssync_d = 1'b1;
        saddr_d = raddr_q;
        sdata_d = rinr_q ? ram_rdata : ERR_WORD;
        rd_inc  = rinr_q;
        err_inc = !rinr_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      ssync_q <= 1'b0;
      sdata_q <= '0;
      saddr_q <= '0;
      raddr_q <= '0;
      rinr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ssync_q <= ssync_d;
      sdata_q <= sdata_d;
      saddr_q <= saddr_d;
      raddr_q <= raddr_d;
      rinr_q  <= rinr_d;
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (wr_inc  && !(&wr_cnt_q))  wr_cnt_q  <= wr_cnt_q  + CNT_W'(1);
      if (rd_inc  && !(&rd_cnt_q))  rd_cnt_q  <= rd_cnt_q  + CNT_W'(1);
      if (err_inc && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  shk_sp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk_i   (i_sys_clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_idx),
    .wdata_i (i_shk_mdata),
    .rdata_o (ram_rdata)
  );

  assign o_shk_ready = ready_q;
  assign o_shk_ssync = ssync_q;
  assign o_shk_sdata = sdata_q;
  assign o_shk_saddr = saddr_q;
  assign o_wr_cnt    = wr_cnt_q;
  assign o_rd_cnt    = rd_cnt_q;
  assign o_err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_shk_mem_slave.sv
// Bench for shk_mem_slave: table of beats with expected responses, scoreboard
// of expected echoes/read data with arrival cycle, plus reset and saturation sequences.
module tb_shk_mem_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, msync;
  logic [31:0] mdata, maddr;
  logic        ready, ssync;
  logic [31:0] sdata, saddr;
  logic [3:0]  wr_cnt, rd_cnt, err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ss   = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    int          exp_wait;
  } vec_t;
  vec_t vecs[10];

  shk_mem_slave #(.CNT_W(4)) dut (
    .i_sys_clk    (clk),
    .i_sys_resetn (rst_n),
    .i_shk_valid  (valid),
    .i_shk_msync  (msync),
    .i_shk_mdata  (mdata),
    .i_shk_maddr  (maddr),
    .o_shk_ready  (ready),
    .o_shk_ssync  (ssync),
    .o_shk_sdata  (sdata),
    .o_shk_saddr  (saddr),
    .o_wr_cnt     (wr_cnt),
    .o_rd_cnt     (rd_cnt),
    .o_err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor: every ssync must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst_n && ssync) begin
      sb_t e;
      n_ss++;
      if (sbq.size() == 0) chk("unexpected_ssync", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("saddr", saddr, e.addr);
        chk("sdata", sdata, e.data);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Presents a beat and holds it until ready; counts cycles spent waiting.
  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ex, input bit push, output int waits);
    @(negedge clk);
    valid = 1'b1; msync = rd; maddr = a; mdata = d; waits = 0;
    while (!ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    else if (push) sbq.push_back('{a, ex, cyc + (rd ? 3 : 1)});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w, n0;
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_00A0, 32'h0000_00A0, 0};
    vecs[1] = '{1'b0, 32'h0000_0001, 32'h0000_00A1, 32'h0000_00A1, 0};
    vecs[2] = '{1'b0, 32'h0000_0002, 32'h0000_00A2, 32'h0000_00A2, 0};
    vecs[3] = '{1'b0, 32'h0000_0003, 32'h0000_00A3, 32'h0000_00A3, 0};
    vecs[4] = '{1'b0, 32'h0000_0005, 32'h1234_5678, 32'h1234_5678, 0};
    vecs[5] = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 0};
    vecs[6] = '{1'b1, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 2};
    vecs[7] = '{1'b0, 32'h0000_0100, 32'hCAFE_0001, 32'hCAFE_0001, 2};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_00A0, 0};
    vecs[9] = '{1'b1, 32'h0000_0001, 32'h0000_0000, 32'h0000_00A1, 2};

    // Reset with valid asserted: nothing may respond.
    rst_n = 1'b0; valid = 1'b1; msync = 1'b0; maddr = '0; mdata = 32'h1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_ssync", {31'd0, ssync}, 32'd0);
    chk("rst_wr_cnt", {28'd0, wr_cnt}, 32'd0);
    chk("rst_rd_cnt", {28'd0, rd_cnt}, 32'd0);
    chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    rst_n = 1'b1; valid = 1'b0;
    #1 chk("release_ready_before_edge", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("release_ready_after_edge", {31'd0, ready}, 32'd1);

    // Table: back-to-back writes, read-after-write, out-of-range read/write.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].exp, 1'b1, w);
      chk($sformatf("ready_wait_%0d", i), w, vecs[i].exp_wait);
    end
    idle(6);
    chk("tbl_wr_cnt", {28'd0, wr_cnt}, 32'd5);
    chk("tbl_rd_cnt", {28'd0, rd_cnt}, 32'd3);
    chk("tbl_err_cnt", {28'd0, err_cnt}, 32'd2);
    chk("tbl_sb_empty", sbq.size(), 32'd0);
    chk("tbl_ssync_count", n_ss, 32'd10);

    // Reset while a read sits in RD_WAIT: response must be dropped.
    n0 = n_ss;
    send(1'b1, 32'h0000_0002, 32'h0, 32'h0, 1'b0, w);
    @(negedge clk);
    valid = 1'b0; rst_n = 1'b0;
    #1 chk("midrd_ready_in_rst", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrd_ready_after", {31'd0, ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrd_no_ssync", n_ss, n0);
    chk("midrd_rd_cnt", {28'd0, rd_cnt}, 32'd0);

    // Saturation of the 4-bit write counter.
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 32'h0000_0007, i, i, 1'b1, w);
      @(posedge clk);
      #1 chk($sformatf("wr_sat_%0d", i), {28'd0, wr_cnt}, (i < 15) ? i + 1 : 15);
    end
    idle(3);
    chk("sat_rd_cnt", {28'd0, rd_cnt}, 32'd0);
    chk("sat_err_cnt", {28'd0, err_cnt}, 32'd0);
    chk("sat_sb_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
